// File: rtl/globals_pkg.sv
// Shared defaults and helpers for the streaming FIFOs.
package globals;

  localparam int FIFO_BUFFER_SIZE   = 16;
  localparam int ALMOST_FULL_MARGIN = 2;

  // Pointer width includes one extra wrap bit above the array index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register array with one synchronous write port and one asynchronous read port.
module fifo_ram #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 16
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0]     wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_SIZE-1:0]     rd_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Contents are never cleared; validity is tracked by the owner's pointers.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with registered wrap-bit pointers.
// Define STREAM_FIFO_ERR_EN to add sticky overflow/underflow flags and a rejected-write counter.
module stream_fifo
  import globals::*;
#(
  parameter int DATA_SIZE          = 32,
  parameter int FIFO_BUFFER_SIZE   = globals::FIFO_BUFFER_SIZE,
  parameter int ALMOST_FULL_MARGIN = globals::ALMOST_FULL_MARGIN
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       wr_en,
  input  logic [DATA_SIZE-1:0]                       din,
  output logic                                       full,
  output logic                                       almost_full,
  input  logic                                       rd_en,
  output logic [DATA_SIZE-1:0]                       dout,
  output logic                                       empty,
`ifdef STREAM_FIFO_ERR_EN
  output logic                                       overflow,
  output logic                                       underflow,
  output logic [15:0]                                drop_count,
`endif
  output logic [ptr_width(FIFO_BUFFER_SIZE)-1:0]     count
);

  localparam int PW = ptr_width(FIFO_BUFFER_SIZE);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_THRESHOLD = PW'(FIFO_BUFFER_SIZE - ALMOST_FULL_MARGIN);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 wr_accept;
  logic                 rd_accept;
  logic [DATA_SIZE-1:0] rd_data;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_THRESHOLD);
  assign wr_accept   = wr_en && !full;
  assign rd_accept   = rd_en && !empty;
  assign dout        = empty ? '0 : rd_data;

  // Pointers wrap freely; the extra MSB distinguishes full from empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (FIFO_BUFFER_SIZE)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_accept && !reset),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (din),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

`ifdef STREAM_FIFO_ERR_EN
  // Error flags are sticky until reset; the drop counter saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed-vector bench for stream_fifo; the error-status ports are checked when STREAM_FIFO_ERR_EN is defined.
module tb_stream_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] din   = '0;
  logic        rd_en = 1'b0;
  logic        full;
  logic        almost_full;
  logic [31:0] dout;
  logic        empty;
  logic [4:0]  count;
`ifdef STREAM_FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
  logic [15:0] drop_count;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  stream_fifo #(
    .DATA_SIZE          (32),
    .FIFO_BUFFER_SIZE   (16),
    .ALMOST_FULL_MARGIN (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
`ifdef STREAM_FIFO_ERR_EN
    .overflow    (overflow),
    .underflow   (underflow),
    .drop_count  (drop_count),
`endif
    .count       (count)
  );

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
    vectors++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_af got %b want 0", almost_full); end
    vectors++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    vectors++; if (dout !== 32'd0) begin errors++; $display("[TB] FAIL reset_dout got %h want 0", dout); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (count !== 5'd0 || empty !== 1'b1) begin
        errors++; $display("[TB] FAIL idle_read count=%0d empty=%b want 0/1", count, empty);
      end
    end
    rd_en = 1'b0;
`ifdef STREAM_FIFO_ERR_EN
    vectors++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow got %b want 1", underflow); end
`endif
  endtask

  task automatic test_fill();
    do_reset();
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      din = 32'(i);
      tick();
      vectors++; if (count !== 5'(i)) begin errors++; $display("[TB] FAIL fill_count got %0d want %0d", count, i); end
      vectors++; if (almost_full !== (i >= 14)) begin errors++; $display("[TB] FAIL fill_af at %0d got %b", i, almost_full); end
      vectors++; if (full !== (i == 16)) begin errors++; $display("[TB] FAIL fill_full at %0d got %b", i, full); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    din   = 32'hDEAD;
    tick();
    wr_en = 1'b0;
    vectors++; if (count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_state count=%0d full=%b want 16/1", count, full);
    end
`ifdef STREAM_FIFO_ERR_EN
    vectors++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL drop_count got %0d want 1", drop_count); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_flag got %b want 1", overflow); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      vectors++; if (dout !== 32'(i) || empty !== 1'b0) begin
        errors++; $display("[TB] FAIL drain_dout got %h empty=%b want %h", dout, empty, i);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      if (i == 1) begin
        vectors++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL drain_full got %b want 0", full); end
      end
    end
    vectors++; if (empty !== 1'b1 || dout !== 32'd0) begin
      errors++; $display("[TB] FAIL drain_end empty=%b dout=%h want 1/0", empty, dout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'(100 + i);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 32'(105 + k);
      vectors++; if (dout !== 32'(100 + k)) begin errors++; $display("[TB] FAIL b2b_dout got %0d want %0d", dout, 100 + k); end
      tick();
      vectors++; if (count !== 5'd5) begin errors++; $display("[TB] FAIL b2b_count got %0d want 5", count); end
    end
    wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++; if (dout !== 32'(103 + k)) begin errors++; $display("[TB] FAIL b2b_order got %0d want %0d", dout, 103 + k); end
      tick();
    end
    rd_en = 1'b0;
    // Both requests while empty: only the write takes effect.
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    vectors++; if (count !== 5'd1 || dout !== 32'h77) begin
      errors++; $display("[TB] FAIL empty_rw count=%0d dout=%h want 1/77", count, dout);
    end
  endtask

  task automatic test_wrap();
    logic signed [31:0] expect_val;
    do_reset();
    wr_en = 1'b1;
    din   = -32'sd20;
    tick();
    rd_en = 1'b1;
    for (int i = 1; i < 40; i++) begin
      din        = 32'(i - 20);
      expect_val = 32'(i - 21);
      vectors++; if (dout !== expect_val) begin errors++; $display("[TB] FAIL wrap_dout at %0d got %0d want %0d", i, $signed(dout), expect_val); end
      tick();
    end
    wr_en = 1'b0;
    expect_val = 32'sd19;
    vectors++; if (dout !== expect_val) begin errors++; $display("[TB] FAIL wrap_last got %0d want 19", $signed(dout)); end
    tick();
    rd_en = 1'b0;
    vectors++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = 32'(200 + i);
      tick();
    end
    vectors++; if (count !== 5'd7) begin errors++; $display("[TB] FAIL mid_pre_count got %0d want 7", count); end
    din = 32'h99; reset = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    vectors++; if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_reset count=%0d empty=%b want 0/1", count, empty);
    end
    wr_en = 1'b1; din = 32'h55;
    tick();
    wr_en = 1'b0;
    vectors++; if (dout !== 32'h55 || count !== 5'd1) begin
      errors++; $display("[TB] FAIL mid_readback dout=%h count=%0d want 55/1", dout, count);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
